axis_block_sig_gen: RTL and testbench
=====================================

Name: axis_block_sig_gen

Overview:
- Producer side of the deadlock-monitor block-signal bus.
- Watches NUM_CH AXI-Stream channel handshakes of one HLS instance.
- Drives one registered "blocked" bit per channel: the channel has stalled for STALL_THRESH consecutive non-idle cycles.
- Also latches the first channel to block, for the simulation deadlock report.
- Sits in the sim wrapper. Its axis_block_sigs output feeds the deadlock monitor tree.

Parameters:
- NUM_CH, 15: number of monitored AXI-Stream channels, 1..32.
- STALL_THRESH, 1024: consecutive stall cycles before a channel reports blocked, >=1.
- CONS_MASK, 15'h0003: per-channel side select, 1 bit per channel.
  - bit=1: consumer side; stall = TREADY & ~TVALID.
  - bit=0: producer side; stall = TVALID & ~TREADY.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ch_tvalid  in  NUM_CH  TVALID of each monitored channel.
- ch_tready  in  NUM_CH  TREADY of each monitored channel.
- inst_idle  in  1  owning instance idle; suppresses and clears all stall counting.
- clear_first  in  1  single-cycle pulse; clears the first-block capture.
- axis_block_sigs  out  NUM_CH  registered per-channel blocked flags.
- first_block_vld  out  1  sticky flag; a first blocked channel has been captured.
- first_block_idx  out  5  index of the first channel to block.
- any_block  out  1  registered OR of axis_block_sigs.

Behaviour:
- Reset values: all counters 0, axis_block_sigs 0, first_block_vld 0, first_block_idx 0, any_block 0.
- Reset takes effect on the next edge, including mid-stall. A counter at any value returns to 0.
- Counter per channel i:
  - Width CW = clog2(STALL_THRESH+1). Unsigned, saturates at STALL_THRESH.
  - stall_i = CONS_MASK[i] ? (tready_i & ~tvalid_i) : (tvalid_i & ~tready_i).
  - Each edge:
    - if inst_idle, cnt_i <= 0;
    - else if stall_i, cnt_i <= min(cnt_i+1, STALL_THRESH);
    - else cnt_i <= 0.
  - A transfer (tvalid & tready) is never a stall, so it clears the counter.
  - Idle & stall together: idle wins, counter clears.
- Block flag:
  - axis_block_sigs[i] <= (next cnt_i == STALL_THRESH).
  - Asserts at the edge ending the STALL_THRESH-th consecutive stall cycle. That is the same edge the counter saturates.
  - Deasserts at the first edge where stall_i=0 or inst_idle=1.
  - Holds high indefinitely while the stall persists. The counter does not wrap.
- any_block is registered from the next values of axis_block_sigs. It is cycle-aligned with axis_block_sigs.
- First-block capture:
  - rise_i = next block_i & ~current block_i.
  - If first_block_vld=0 and any rise_i: first_block_vld <= 1, first_block_idx <= lowest i with rise_i.
  - Simultaneous rises: the lowest index wins.
  - While first_block_vld=1, further rises are ignored. The capture is sticky.
  - clear_first=1 with no rise: first_block_vld <= 0, first_block_idx <= 0.
  - clear_first=1 in the same cycle as a rise: re-capture. vld stays 1 and idx takes the new lowest rising index.
  - A channel already blocked when clear_first fires is not re-captured until it drops and rises again.
- Unused first_block_idx bits (index >= NUM_CH) are never produced.
- No combinational path from any input to any output.

Test Plan:
Setup for all: NUM_CH=15, STALL_THRESH=4, CONS_MASK=15'h0003.

1. Ch2 producer stall.
   - Stimulus: ch_tvalid[2]=1, ch_tready[2]=0 from cycle 0, inst_idle=0.
   - Required: axis_block_sigs[2] and any_block go 1 after the 4th edge.
   - Required: first_block_vld=1, first_block_idx=2.
   - Then raise tready[2] for 1 cycle -> block[2]=0 at the next edge.
2. Ch0 consumer stall interrupted.
   - Stimulus: tready[0]=1, tvalid[0]=0 for 3 cycles, then 1 transfer cycle, then 3 stall cycles.
   - Required: axis_block_sigs[0] never asserts; the counter restarts from 0.
3. Idle suppression.
   - Stimulus: ch5 stalled for 10 cycles with inst_idle=1 throughout.
   - Required: block[5]=0 throughout.
   - Stimulus: drop idle -> block[5]=1 exactly 4 edges later.
4. Simultaneous block and sticky capture.
   - Stimulus: ch7 and ch3 stall starting on the same cycle.
   - Required: both flags rise together; first_block_idx=3.
   - Stimulus: later ch1 blocks -> idx stays 3.
   - Stimulus: clear_first pulse, then ch9 rises -> idx=9.
5. clear_first coincident with rise.
   - Stimulus: first_block_vld=1 (idx=4); pulse clear_first on the same edge ch12 reaches the threshold.
   - Required: vld stays 1, idx=12.
6. Reset mid-stall.
   - Stimulus: ch6 counter at 3; assert reset 1 cycle; keep the stall.
   - Required: all outputs 0 after the reset edge; block[6] reasserts 4 edges after reset deasserts.

Source files
------------

// File: rtl/axis_block_sig_gen.sv
// Per-channel AXI-Stream stall detector for the deadlock-monitor block-signal bus.
// Flags channels stalled STALL_THRESH consecutive non-idle cycles and latches the first to block.
module axis_block_sig_gen #(
  parameter int              NUM_CH       = 15,
  parameter int              STALL_THRESH = 1024,
  parameter logic [NUM_CH-1:0] CONS_MASK  = NUM_CH'(15'h0003)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  input  logic              inst_idle,
  input  logic              clear_first,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              first_block_vld,
  output logic [4:0]        first_block_idx,
  output logic              any_block
);

  localparam int CW = $clog2(STALL_THRESH + 1);
  localparam logic [CW-1:0] THRESH = CW'(STALL_THRESH);

  logic [CW-1:0]     cnt     [NUM_CH];
  logic [CW-1:0]     cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] blk_nxt;
  logic [NUM_CH-1:0] rise;
  logic              rise_found;
  logic [4:0]        rise_idx;
  logic              vld_nxt;
  logic [4:0]        idx_nxt;

  always_comb begin
    stall   = '0;
    blk_nxt = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      stall[i] = CONS_MASK[i] ? (ch_tready[i] & ~ch_tvalid[i])
                              : (ch_tvalid[i] & ~ch_tready[i]);
      if (inst_idle || !stall[i])
        cnt_nxt[i] = '0;
      else if (cnt[i] == THRESH)
        cnt_nxt[i] = cnt[i];
      else
        cnt_nxt[i] = cnt[i] + 1'b1;
      blk_nxt[i] = (cnt_nxt[i] == THRESH);
    end
  end

  // Lowest rising index wins when several channels block on the same edge.
  always_comb begin
    rise       = blk_nxt & ~axis_block_sigs;
    rise_found = 1'b0;
    rise_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rise[i] && !rise_found) begin
        rise_found = 1'b1;
        rise_idx   = 5'(i);
      end
    end
  end

  // clear_first coinciding with a rise re-captures instead of clearing.
  always_comb begin
    vld_nxt = first_block_vld;
    idx_nxt = first_block_idx;
    if ((!first_block_vld || clear_first) && rise_found) begin
      vld_nxt = 1'b1;
      idx_nxt = rise_idx;
    end else if (clear_first) begin
      vld_nxt = 1'b0;
      idx_nxt = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      axis_block_sigs <= '0;
      any_block       <= 1'b0;
      first_block_vld <= 1'b0;
      first_block_idx <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
      axis_block_sigs <= blk_nxt;
      any_block       <= |blk_nxt;
      first_block_vld <= vld_nxt;
      first_block_idx <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_axis_block_sig_gen.sv
// Directed-vector bench for axis_block_sig_gen (NUM_CH=15, STALL_THRESH=4, CONS_MASK=15'h0003).
// Driver pushes hand-computed expectations; a monitor pops one per clock and compares.
module tb_axis_block_sig_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] ch_tvalid = '0;
  logic [14:0] ch_tready = '0;
  logic        inst_idle = 1'b0;
  logic        clear_first = 1'b0;
  logic [14:0] axis_block_sigs;
  logic        first_block_vld;
  logic [4:0]  first_block_idx;
  logic        any_block;

  logic [14:0] tv_s = '0;
  logic [14:0] tr_s = '0;

  typedef struct {
    logic [14:0] blk;
    logic        any;
    logic        vld;
    logic [4:0]  idx;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  axis_block_sig_gen #(
    .NUM_CH(15),
    .STALL_THRESH(4),
    .CONS_MASK(15'h0003)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ch_tvalid(ch_tvalid),
    .ch_tready(ch_tready),
    .inst_idle(inst_idle),
    .clear_first(clear_first),
    .axis_block_sigs(axis_block_sigs),
    .first_block_vld(first_block_vld),
    .first_block_idx(first_block_idx),
    .any_block(any_block)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs and queue the outputs required after the next edge.
  task automatic step(input int n, input logic rst_i, input logic idle_i, input logic clr_i,
                      input logic [14:0] eblk, input logic evld, input logic [4:0] eidx,
                      input string nm);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      reset       = rst_i;
      inst_idle   = idle_i;
      clear_first = clr_i;
      ch_tvalid   = tv_s;
      ch_tready   = tr_s;
      e.blk = eblk;
      e.any = |eblk;
      e.vld = evld;
      e.idx = eidx;
      e.nm  = nm;
      exp_q.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (axis_block_sigs !== e.blk) begin
          errors++;
          $display("FAIL %s blk: got %h want %h", e.nm, axis_block_sigs, e.blk);
        end
        checks++;
        if (any_block !== e.any) begin
          errors++;
          $display("FAIL %s any: got %b want %b", e.nm, any_block, e.any);
        end
        checks++;
        if (first_block_vld !== e.vld) begin
          errors++;
          $display("FAIL %s vld: got %b want %b", e.nm, first_block_vld, e.vld);
        end
        checks++;
        if (first_block_idx !== e.idx) begin
          errors++;
          $display("FAIL %s idx: got %0d want %0d", e.nm, first_block_idx, e.idx);
        end
      end
    end
  end

  initial begin : driver
    step(2, 1, 0, 0, 15'h0000, 0, 0, "reset");

    // 1: ch2 producer stall
    tv_s[2] = 1'b1;
    step(3, 0, 0, 0, 15'h0000, 0, 0, "t1_count");
    step(2, 0, 0, 0, 15'h0004, 1, 2, "t1_block");
    tr_s[2] = 1'b1;
    step(1, 0, 0, 0, 15'h0000, 1, 2, "t1_release");
    tv_s[2] = 1'b0; tr_s[2] = 1'b0;

    // 2: ch0 consumer stall interrupted by a transfer
    tr_s[0] = 1'b1;
    step(3, 0, 0, 0, 15'h0000, 1, 2, "t2_stall_a");
    tv_s[0] = 1'b1;
    step(1, 0, 0, 0, 15'h0000, 1, 2, "t2_xfer");
    tv_s[0] = 1'b0;
    step(3, 0, 0, 0, 15'h0000, 1, 2, "t2_stall_b");
    step(1, 0, 0, 0, 15'h0001, 1, 2, "t2_sticky");
    tr_s[0] = 1'b0;
    step(1, 0, 0, 0, 15'h0000, 1, 2, "t2_release");

    // 3: idle suppression, then clear_first with no rise
    tv_s[5] = 1'b1;
    step(10, 0, 1, 0, 15'h0000, 1, 2, "t3_idle");
    step(3, 0, 0, 0, 15'h0000, 1, 2, "t3_count");
    step(1, 0, 0, 0, 15'h0020, 1, 2, "t3_block");
    tv_s[5] = 1'b0;
    step(1, 0, 0, 0, 15'h0000, 1, 2, "t3_release");
    step(1, 0, 0, 1, 15'h0000, 0, 0, "t3_clear");

    // 4: simultaneous rise, sticky capture, re-capture after clear
    tv_s[3] = 1'b1; tv_s[7] = 1'b1;
    step(3, 0, 0, 0, 15'h0000, 0, 0, "t4_count");
    step(1, 0, 0, 0, 15'h0088, 1, 3, "t4_simul");
    tr_s[1] = 1'b1;
    step(3, 0, 0, 0, 15'h0088, 1, 3, "t4_ch1_count");
    step(1, 0, 0, 0, 15'h008a, 1, 3, "t4_ch1_sticky");
    step(1, 0, 0, 1, 15'h008a, 0, 0, "t4_clear");
    tv_s[9] = 1'b1;
    step(3, 0, 0, 0, 15'h008a, 0, 0, "t4_ch9_count");
    step(1, 0, 0, 0, 15'h028a, 1, 9, "t4_ch9_capture");
    tv_s = '0; tr_s = '0;
    step(1, 0, 0, 0, 15'h0000, 1, 9, "t4_release");

    // 5: clear_first coincident with ch12 reaching threshold
    step(1, 0, 0, 1, 15'h0000, 0, 0, "t5_clear");
    tv_s[4] = 1'b1;
    step(3, 0, 0, 0, 15'h0000, 0, 0, "t5_ch4_count");
    step(1, 0, 0, 0, 15'h0010, 1, 4, "t5_ch4_capture");
    tv_s[12] = 1'b1;
    step(3, 0, 0, 0, 15'h0010, 1, 4, "t5_ch12_count");
    step(1, 0, 0, 1, 15'h1010, 1, 12, "t5_recapture");
    step(1, 0, 0, 0, 15'h1010, 1, 12, "t5_hold");
    step(1, 0, 0, 1, 15'h1010, 0, 0, "t5_clear_blocked");
    step(1, 0, 0, 0, 15'h1010, 0, 0, "t5_no_recapture");
    tv_s = '0;
    step(1, 0, 0, 0, 15'h0000, 0, 0, "t5_release");

    // 6: reset with ch6 counter at 3, stall held throughout
    tv_s[6] = 1'b1;
    step(3, 0, 0, 0, 15'h0000, 0, 0, "t6_count");
    step(1, 1, 0, 0, 15'h0000, 0, 0, "t6_reset");
    step(3, 0, 0, 0, 15'h0000, 0, 0, "t6_recount");
    step(1, 0, 0, 0, 15'h0040, 1, 6, "t6_reblock");
    tv_s = '0;
    step(1, 0, 0, 0, 15'h0000, 1, 6, "t6_release");

    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
